// File: rtl/tick_pkg.sv
// Shared definitions for the tick divider / period meter pair.
package tick_pkg;

  // Width of the divider's div field; the meter defaults to the same width.
  localparam int TICK_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE
  } state_t;

endpackage

// File: rtl/period_lock_det.sv
// Lock detector: tracks how many consecutive measurements matched the
// previous one and raises locked once LOCK_COUNT equal values are seen.
module period_lock_det #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             meas,
  input  logic [WIDTH-1:0] value,
  output logic             locked
);

  localparam int SW = $clog2(LOCK_COUNT);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_COUNT - 1);

  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic [SW-1:0]    stable;
  logic [SW-1:0]    stable_next;

  // Saturating match count for the measurement arriving this cycle.
  always_comb begin
    stable_next = '0;
    if (prev_ok && (value == prev)) begin
      stable_next = (stable == STABLE_MAX) ? stable : stable + SW'(1);
    end
  end

  // Control state: cleared on reset, disable, arming or overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_ok <= 1'b0;
      stable  <= '0;
      locked  <= 1'b0;
    end else if (meas) begin
      prev_ok <= 1'b1;
      stable  <= stable_next;
      locked  <= (stable_next == STABLE_MAX);
    end
  end

  // Previous measured value; only meaningful while prev_ok is set.
  always_ff @(posedge clk) begin
    if (meas) begin
      prev <= value;
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Measures the number of non-tick cycles between consecutive ticks,
// reporting the recovered divider value and a lock indication.
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int WIDTH      = TICK_WIDTH,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic             at_max;
  logic             meas;
  logic             clear;

  // A tick at counter==CNT_MAX is still a valid measurement; only a
  // non-tick cycle at the limit overflows.
  assign at_max = (counter == CNT_MAX);
  assign meas   = en && (state == MEASURE) && tick_in;
  assign clear  = !en || (state != MEASURE) || (!tick_in && at_max);

  // FSM, interval counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (tick_in) begin
              counter <= '0;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (tick_in) begin
              period       <= counter;
              period_valid <= 1'b1;
              counter      <= '0;
            end else if (at_max) begin
              overflow <= 1'b1;
              counter  <= '0;
              state    <= WAIT_FIRST;
            end else begin
              counter <= counter + WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  period_lock_det #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .meas   (meas),
    .value  (counter),
    .locked (locked)
  );

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter: a default-width instance checked through
// a scoreboard of expected measurements, plus an 8-bit, LOCK_COUNT=2
// instance that exercises the counter limit and overflow path.
module tb_tick_period_meter;

  typedef struct packed {
    logic [15:0] period;
    logic        locked;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, tick_in;
  logic [15:0] period;
  logic        period_valid, locked, overflow;

  logic        s_en, s_tick;
  logic [7:0]  s_period;
  logic        s_pv, s_locked, s_ov;

  int n_cmp = 0;
  int n_err = 0;
  int ov_main_cnt = 0;
  int s_ov_cnt = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  tick_period_meter u_dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  tick_period_meter #(.WIDTH(8), .LOCK_COUNT(2)) u_small (
    .clk          (clk),
    .rst          (rst),
    .en           (s_en),
    .tick_in      (s_tick),
    .period       (s_period),
    .period_valid (s_pv),
    .locked       (s_locked),
    .overflow     (s_ov)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // d non-tick cycles then a closing tick; the expected result is queued.
  task automatic send_interval(input int d, input logic exp_lock);
    exp_t e;
    tick_in = 1'b0;
    repeat (d) step();
    e.period = d[15:0];
    e.locked = exp_lock;
    q.push_back(e);
    tick_in = 1'b1;
    step();
  endtask

  // Scoreboard: every period_valid pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (overflow) ov_main_cnt++;
    if (s_ov) s_ov_cnt++;
    if (period_valid) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_pv: observed period %0d expected no pulse", period);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        assert (period === e.period) else begin
          n_err++;
          $error("FAIL sb_period: observed %0d expected %0d", period, e.period);
        end
        n_cmp++;
        assert (locked === e.locked) else begin
          n_err++;
          $error("FAIL sb_locked: observed %0d expected %0d (period %0d)", locked, e.locked, e.period);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; tick_in = 1'b0; s_en = 1'b0; s_tick = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_period", 32'(period), 0);
    chk("rst_pv", 32'(period_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Enable with a tick in the IDLE cycle (ignored), then arm.
    en = 1'b1; tick_in = 1'b1; step();
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    chk("arm_no_pv", 32'(period_valid), 0);

    // D=4: lock on the 4th measurement.
    send_interval(4, 1'b0);
    send_interval(4, 1'b0);
    send_interval(4, 1'b0);
    send_interval(4, 1'b1);
    send_interval(4, 1'b1);

    // D=0: ticks held high.
    send_interval(0, 1'b0);
    send_interval(0, 1'b0);
    send_interval(0, 1'b0);
    send_interval(0, 1'b1);
    send_interval(0, 1'b1);

    // D=9 lock, one short interval of 7, then relock.
    send_interval(9, 1'b0);
    send_interval(9, 1'b0);
    send_interval(9, 1'b0);
    send_interval(9, 1'b1);
    send_interval(7, 1'b0);
    send_interval(9, 1'b0);
    send_interval(9, 1'b0);
    send_interval(9, 1'b0);
    send_interval(9, 1'b1);

    // Lock at D=3, then drop en mid-interval with a coincident tick.
    send_interval(3, 1'b0);
    send_interval(3, 1'b0);
    send_interval(3, 1'b0);
    send_interval(3, 1'b1);
    tick_in = 1'b0; step(); step();
    en = 1'b0; tick_in = 1'b1; step();
    chk("en_off_locked", 32'(locked), 0);
    chk("en_off_period", 32'(period), 3);
    chk("en_off_pv", 32'(period_valid), 0);
    tick_in = 1'b0; step();
    en = 1'b1; tick_in = 1'b1; step();
    step();
    chk("reen_period_hold", 32'(period), 3);
    send_interval(3, 1'b0);
    send_interval(3, 1'b0);
    send_interval(3, 1'b0);
    send_interval(3, 1'b1);

    // Reset mid-interval while locked.
    tick_in = 1'b0; step(); step();
    rst = 1'b1; step();
    chk("rst_mid_locked", 32'(locked), 0);
    chk("rst_mid_period", 32'(period), 0);
    rst = 1'b0; step();
    tick_in = 1'b1; step();
    chk("rst_arm_no_pv", 32'(period_valid), 0);
    send_interval(3, 1'b0);
    tick_in = 1'b0; repeat (3) step();
    chk("sb_drained", 32'(q.size()), 0);
    chk("main_no_ovf", 32'(ov_main_cnt), 0);

    // 8-bit instance: interval of exactly 255 is a measurement.
    s_en = 1'b1; step();
    s_tick = 1'b1; step();
    s_tick = 1'b0; repeat (255) step();
    s_tick = 1'b1; step();
    chk("max_pv", 32'(s_pv), 1);
    chk("max_period", 32'(s_period), 255);
    chk("max_no_ovf", 32'(s_ov), 0);

    // 256 non-tick cycles: single overflow pulse, period held.
    s_tick = 1'b0; repeat (255) step();
    chk("pre_ovf", 32'(s_ov), 0);
    step();
    chk("ovf_pulse", 32'(s_ov), 1);
    chk("ovf_no_pv", 32'(s_pv), 0);
    chk("ovf_period_hold", 32'(s_period), 255);
    step();
    chk("ovf_one_cycle", 32'(s_ov), 0);
    chk("ovf_count", 32'(s_ov_cnt), 1);

    // Back in WAIT_FIRST: next tick only arms.
    s_tick = 1'b1; step();
    chk("ovf_rearm_no_pv", 32'(s_pv), 0);
    s_tick = 1'b0; step(); step();
    s_tick = 1'b1; step();
    chk("s_first_pv", 32'(s_pv), 1);
    chk("s_first_period", 32'(s_period), 2);
    chk("s_first_unlocked", 32'(s_locked), 0);
    s_tick = 1'b0; step(); step();
    s_tick = 1'b1; step();
    chk("s_lock2_period", 32'(s_period), 2);
    chk("s_lock2_locked", 32'(s_locked), 1);
    step();
    chk("s_mismatch_period", 32'(s_period), 0);
    chk("s_mismatch_unlock", 32'(s_locked), 0);
    s_tick = 1'b0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Recovers the divisor of a one-cycle tick train generated in the same clock domain by the team's programmable tick divider. That divider asserts its output for one cycle every div+1 cycles.
- The block measures the number of non-tick cycles between consecutive ticks. It reports that count as the recovered div value and flags lock once the interval is stable.
- Sits beside the divider in self-check and bring-up paths, and on any tick input whose rate must be verified.

Parameters:
- WIDTH, 16, width of the measured period and the internal counter; matches the divider's div width.
- LOCK_COUNT, 4, number of consecutive identical measurements required to assert locked; legal values are 2 or more.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  measurement enable; low forces IDLE.
- tick_in  in  1  tick stream; every cycle sampled high is one tick event, so consecutive high cycles are separate ticks.
- period  out  WIDTH  last measured interval, in non-tick cycles between two ticks (equals the divider's div).
- period_valid  out  1  one-cycle pulse when period updates.
- locked  out  1  high while the last LOCK_COUNT measurements are all equal.
- overflow  out  1  one-cycle pulse when an interval exceeds 2^WIDTH-1 non-tick cycles.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; counter=0; stable count=0.
  - period=0, period_valid=0, locked=0, overflow=0.
  - Reset mid-measurement discards the partial interval; the first tick after reset only arms the block.
- States: IDLE, WAIT_FIRST, MEASURE.
- IDLE:
  - en=1 moves to WAIT_FIRST; tick_in is ignored in that cycle.
  - Outputs other than period are held low.
- WAIT_FIRST:
  - tick_in=1 sets counter<=0 and moves to MEASURE; no measurement is produced.
- MEASURE, tick_in=0, counter below 2^WIDTH-1: counter<=counter+1.
- MEASURE, tick_in=1:
  - period<=counter; period_valid=1 in the following cycle (latency 1 cycle from the closing tick).
  - counter<=0; state stays MEASURE, so each closing tick also opens the next interval.
- Expected results:
  - Divider div=D gives period=D on every tick after the first.
  - Back-to-back ticks give period=0.
- Overflow:
  - Condition: MEASURE, tick_in=0 and counter==2^WIDTH-1.
  - Effect: overflow pulses for 1 cycle; state moves to WAIT_FIRST; locked<=0; stable count<=0; period holds its old value; no period_valid.
  - A tick arriving when counter==2^WIDTH-1 is a valid measurement of 2^WIDTH-1, not an overflow.
- Lock detection, on each measurement:
  - If the new value equals the previous period, stable count increments, saturating at LOCK_COUNT-1; otherwise stable count<=0.
  - locked = (stable count == LOCK_COUNT-1); it updates in the same cycle as period_valid.
  - The first measurement after arming is never compared; the previous-value comparison is invalid until one measurement exists.
  - A mismatch drops locked in the same cycle the mismatching period_valid is seen.
- en deasserted in any state:
  - Next state IDLE; counter<=0; stable count<=0; locked<=0; period_valid<=0.
  - period holds.
  - A tick in the same cycle as en falling is ignored.
- Widths:
  - counter and period are WIDTH bits, unsigned; there is no wrap-around, because overflow is handled explicitly.
  - stable count is $clog2(LOCK_COUNT) bits.

Decomposition:
- Shared package tick_pkg:
  - state enum (IDLE, WAIT_FIRST, MEASURE);
  - TICK_WIDTH=16 constant, shared with the divider.
- One natural sub-module, period_lock_det. It holds the previous-period register, equality compare and saturating stable counter. It takes a measurement strobe, value and clear, and outputs locked.
- Top-level contents: FSM, interval counter, output registers.

Test Plan:
- Reset then en=1, ticks every 5 cycles (D=4) -> first tick gives no pulse; each following tick gives period_valid 1 cycle later with period=4; locked rises on the 4th period_valid.
- Ticks held high continuously (D=0) -> period=0 on every cycle after the first tick; locked after 4 measurements.
- Locked at D=9, then one interval of 7 non-tick cycles -> period=7, locked falls with that period_valid; relocks after 3 further D=9 intervals following the first.
- One tick then tick_in low for 65536 cycles -> overflow pulses exactly once; period unchanged; state WAIT_FIRST.
- Interval of exactly 65535 non-tick cycles -> period=65535 with no overflow.
- rst, or en=0, asserted mid-interval while locked at D=3 -> locked=0 next cycle; after re-enable, the first tick produces no period_valid; period keeps 3 (en case) or reads 0 (rst case).
